// File: rtl/pkg_bram_if.sv
// Shared types and sizing for the pipelined min-select tournament.
// Holds: NUM_ENTRY/WIDTH_KEY build sizes, LEVELS derivation, pad key, candidate struct.
// Optional feature macro: TOURNAMENT_RR_EN (round-robin tie-break).
package pkg_bram_if;

  localparam int NUM_ENTRY = 20;
  localparam int WIDTH_KEY = 4;
  localparam int IDX_W     = $clog2(NUM_ENTRY);

  function automatic int levels_of(input int n);
    int lv;
    int cap;
    lv  = 0;
    cap = 1;
    while (cap < n) begin
      cap = cap * 4;
      lv  = lv + 1;
    end
    return lv;
  endfunction

  localparam int LEVELS = levels_of(NUM_ENTRY);
  localparam int LANES  = 1 << (2 * LEVELS);

  localparam logic [WIDTH_KEY-1:0] PAD_KEY = '1;

  typedef struct packed {
    logic                 valid;
    logic [WIDTH_KEY-1:0] key;
    logic [IDX_W-1:0]     idx;
  } cand_t;

  localparam cand_t PAD_CAND = '{valid: 1'b0, key: PAD_KEY, idx: '0};

`ifdef TOURNAMENT_RR_EN
  // Rotated distance (idx - ptr) mod NUM_ENTRY, one extra bit for the borrow.
  function automatic logic [IDX_W-1:0] rr_dist(
    input logic [IDX_W-1:0] idx,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W:0] d;
    d = {1'b0, idx} - {1'b0, ptr};
    if (idx < ptr)
      d = d + (IDX_W+1)'(NUM_ENTRY);
    return IDX_W'(d);
  endfunction

  function automatic logic beats(
    input cand_t            a,
    input cand_t            b,
    input logic [IDX_W-1:0] ptr
  );
    if (a.valid != b.valid)
      return a.valid;
    if (!a.valid)
      return 1'b0;
    if (a.key != b.key)
      return a.key < b.key;
    return rr_dist(a.idx, ptr) < rr_dist(b.idx, ptr);
  endfunction
`else
  function automatic logic beats(
    input cand_t a,
    input cand_t b
  );
    if (a.valid != b.valid)
      return a.valid;
    if (!a.valid)
      return 1'b0;
    if (a.key != b.key)
      return a.key < b.key;
    return a.idx < b.idx;
  endfunction
`endif

endpackage

// File: rtl/tournament_cell4.sv
// Combinational 4-way min-select over {valid, key, index} candidates.
// Ports: ptr (tie pointer, TOURNAMENT_RR_EN only), c0..c3 in, win out.
module tournament_cell4
  import pkg_bram_if::*;
(
`ifdef TOURNAMENT_RR_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  input  cand_t            c0,
  input  cand_t            c1,
  input  cand_t            c2,
  input  cand_t            c3,
  output cand_t            win
);

`ifdef TOURNAMENT_RR_EN
  function automatic logic bt(input cand_t a, input cand_t b);
    return beats(a, b, ptr);
  endfunction
`else
  function automatic logic bt(input cand_t a, input cand_t b);
    return beats(a, b);
  endfunction
`endif

  cand_t lo;
  cand_t hi;
  cand_t m;

  always_comb begin
    lo  = bt(c1, c0) ? c1 : c0;
    hi  = bt(c3, c2) ? c3 : c2;
    m   = bt(hi, lo) ? hi : lo;
    win = m;
    // An all-invalid group reports the pad key and index 0.
    if (!m.valid) begin
      win.key = PAD_KEY;
      win.idx = '0;
    end
  end

endmodule

// File: rtl/tournament_pipe.sv
// Pipelined radix-4 min-select tournament with valid/ready on both sides.
// Ports: clock, reset (sync, active-low); I_Req/O_Rdy/I_Key/I_Vld in;
// O_Valid/I_Ack/O_Key/O_Grant/O_Index/O_None out. Macro: TOURNAMENT_RR_EN.
module tournament_pipe
  import pkg_bram_if::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 I_Req,
  output logic                 O_Rdy,
  input  logic [WIDTH_KEY-1:0] I_Key [NUM_ENTRY],
  input  logic [NUM_ENTRY-1:0] I_Vld,
  output logic                 O_Valid,
  input  logic                 I_Ack,
  output logic [WIDTH_KEY-1:0] O_Key,
  output logic [NUM_ENTRY-1:0] O_Grant,
  output logic [IDX_W-1:0]     O_Index,
  output logic                 O_None
);

  logic  adv;
  logic  take;
  cand_t lane [LANES];
  cand_t last;
  logic  last_sv;

  assign adv   = ~O_Valid | I_Ack;
  assign O_Rdy = adv & reset;
  assign take  = I_Req & O_Rdy;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i < NUM_ENTRY) begin : g_real
      assign lane[i] = '{valid: I_Vld[i],
                         key:   I_Key[i],
                         idx:   IDX_W'(i)};
    end else begin : g_pad
      assign lane[i] = PAD_CAND;
    end
  end

`ifdef TOURNAMENT_RR_EN
  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clock) begin
    if (!reset)
      ptr_q <= '0;
    else if (O_Valid && I_Ack && !O_None)
      ptr_q <= (O_Index == IDX_W'(NUM_ENTRY - 1)) ? '0 : O_Index + 1'b1;
  end
`endif

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NOUT = LANES >> (2 * (l + 1));

    cand_t d [4*NOUT];
    cand_t w [NOUT];
    cand_t q [NOUT];
    logic  sv_in;
    logic  sv;
`ifdef TOURNAMENT_RR_EN
    logic [IDX_W-1:0] p_in;
`endif

    if (l == 0) begin : g_head
      assign d     = lane;
      assign sv_in = take;
`ifdef TOURNAMENT_RR_EN
      assign p_in  = ptr_q;
`endif
    end else begin : g_body
      assign d     = g_lvl[l-1].q;
      assign sv_in = g_lvl[l-1].sv;
`ifdef TOURNAMENT_RR_EN
      assign p_in  = g_lvl[l-1].g_p.p;
`endif
    end

    for (genvar g = 0; g < NOUT; g++) begin : g_cell
      tournament_cell4 u_cell (
`ifdef TOURNAMENT_RR_EN
        .ptr (p_in),
`endif
        .c0  (d[4*g]),
        .c1  (d[4*g+1]),
        .c2  (d[4*g+2]),
        .c3  (d[4*g+3]),
        .win (w[g])
      );
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        sv <= 1'b0;
        for (int i = 0; i < NOUT; i++)
          q[i] <= '0;
      end else if (adv) begin
        sv <= sv_in;
        q  <= w;
      end
    end

`ifdef TOURNAMENT_RR_EN
    // The capture-time pointer rides along so later ties use it.
    if (l < LEVELS - 1) begin : g_p
      logic [IDX_W-1:0] p;
      always_ff @(posedge clock) begin
        if (!reset)
          p <= '0;
        else if (adv)
          p <= p_in;
      end
    end
`endif
  end

  assign last    = g_lvl[LEVELS-1].q[0];
  assign last_sv = g_lvl[LEVELS-1].sv;

  assign O_Valid = last_sv;
  assign O_Key   = last.key;
  assign O_Index = last.idx;
  assign O_None  = last_sv & ~last.valid;
  assign O_Grant = last.valid ? (NUM_ENTRY'(1) << last.idx) : '0;

endmodule
